// File: rtl/counter_seq_ctrl_pkg.sv
// Shared state encoding, default parameters and helpers for the counter sequencer.
package counter_seq_ctrl_pkg;

    localparam int unsigned DEF_DIV   = 4;
    localparam int unsigned DEF_MOD   = 8;
    localparam int unsigned DEF_CNT_W = 3;
    localparam int unsigned DEF_LAPS  = 2;
    localparam int unsigned DEF_LAP_W = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Register width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/counter_seq_ctrl_clk_prescaler.sv
// DIV-ratio phase counter; tc_c marks the last phase of each count-enable period.
module clk_prescaler
    import counter_seq_ctrl_pkg::*;
#(
    parameter int unsigned DIV = DEF_DIV
) (
    input  logic CLK,
    input  logic RST_n,
    input  logic en,
    input  logic hold,
    input  logic clr,
    output logic tc_c
);

    localparam int unsigned   PW   = cnt_width(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] cnt;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !hold) begin
            cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
        end
    end

    assign tc_c = (cnt == LAST);

endmodule

// File: rtl/counter_seq_ctrl.sv
// Run/pause/clear sequencer driving the counter datapath enable/clear and counting laps.
// Build option COUNTER_SEQ_AUTOSTOP_EN: stop in DONE once LAPS wraps have completed.
module counter_seq_ctrl
    import counter_seq_ctrl_pkg::*;
#(
    parameter int unsigned DIV   = DEF_DIV,
    parameter int unsigned MOD   = DEF_MOD,
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned LAPS  = DEF_LAPS,
    parameter int unsigned LAP_W = DEF_LAP_W
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             iStart,
    input  logic             iStop,
    input  logic             iClear,
    input  logic [CNT_W-1:0] iCntQ,
    output logic             oCntEn,
    output logic             oCntClr,
    output logic [LAP_W-1:0] oLaps,
    output logic             oBusy,
    output logic             oDone
);

    if (DIV == 0 || LAPS == 0 || LAP_W >= 32 || (32'd1 << LAP_W) <= LAPS) begin : g_bad_params
        $error("counter_seq_ctrl: DIV, LAPS or LAP_W out of range");
    end

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [LAP_W-1:0] laps_nxt;
    logic             cnt_en_nxt;
    logic             cnt_clr_nxt;
    logic             done_nxt_c;
    logic             start_c;
    logic             wrap_c;
    logic             last_lap_c;
    logic             tc_c;
    logic             pre_en_c;
    logic             pre_hold_c;
    logic             pre_clr_c;

    // iStop outranks iStart whenever both arrive together.
    assign start_c = iStart && !iStop;
    assign wrap_c  = oCntEn && (iCntQ == CNT_W'(MOD - 1));

`ifdef COUNTER_SEQ_AUTOSTOP_EN
    assign last_lap_c = wrap_c && (oLaps == LAP_W'(LAPS - 1));
    assign done_nxt_c = (state_nxt == ST_DONE);
`else
    assign last_lap_c = 1'b0;
    assign done_nxt_c = 1'b0;
`endif

    // Prescaler freezes on stop/clear/auto-stop cycles and restarts from 0 on a fresh run.
    assign pre_en_c   = (state == ST_RUN);
    assign pre_hold_c = iStop || iClear || last_lap_c;
    assign pre_clr_c  = iClear || (start_c && (state == ST_IDLE || state == ST_DONE));

    clk_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .CLK   (CLK),
        .RST_n (RST_n),
        .en    (pre_en_c),
        .hold  (pre_hold_c),
        .clr   (pre_clr_c),
        .tc_c  (tc_c)
    );

    // Next-state and next-output logic; command priority is clear > auto-stop > stop > start.
    always_comb begin
        state_nxt   = state;
        laps_nxt    = wrap_c ? oLaps + LAP_W'(1) : oLaps;
        cnt_en_nxt  = 1'b0;
        cnt_clr_nxt = 1'b0;
        if (iClear) begin
            state_nxt   = ST_IDLE;
            laps_nxt    = '0;
            cnt_clr_nxt = 1'b1;
        end else if (last_lap_c) begin
            state_nxt = ST_DONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_c) state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (iStop) state_nxt = ST_PAUSE;
                    else       cnt_en_nxt = tc_c;
                end
                ST_PAUSE: begin
                    if (start_c) state_nxt = ST_RUN;
                end
                ST_DONE: begin
                    if (start_c) begin
                        state_nxt   = ST_RUN;
                        laps_nxt    = '0;
                        cnt_clr_nxt = 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state   <= ST_IDLE;
            oCntEn  <= 1'b0;
            oCntClr <= 1'b0;
            oLaps   <= '0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
        end else begin
            state   <= state_nxt;
            oCntEn  <= cnt_en_nxt;
            oCntClr <= cnt_clr_nxt;
            oLaps   <= laps_nxt;
            oBusy   <= (state_nxt == ST_RUN);
            oDone   <= done_nxt_c;
        end
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl: directed scenarios plus randomized commands vs a reference model.
module tb_counter_seq_ctrl;

    localparam int DIV   = 4;
    localparam int MOD   = 8;
    localparam int CNT_W = 3;
    localparam int LAPS  = 2;
    localparam int LAP_W = 4;
`ifdef COUNTER_SEQ_AUTOSTOP_EN
    localparam bit AUTOSTOP = 1'b1;
`else
    localparam bit AUTOSTOP = 1'b0;
`endif
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic             CLK    = 1'b0;
    logic             RST_n  = 1'b0;
    logic             iStart = 1'b0;
    logic             iStop  = 1'b0;
    logic             iClear = 1'b0;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;
    logic             en0, clr0, busy0, done0;
    logic             en1, clr1, busy1, done1;
    logic [LAP_W-1:0] laps0, laps1;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state for the DIV=4 instance
    int m_mode, m_ph, m_laps, m_cnt;
    bit m_en, m_clr;

    always #5 CLK = ~CLK;

    counter_seq_ctrl #(
        .DIV(DIV), .MOD(MOD), .CNT_W(CNT_W), .LAPS(LAPS), .LAP_W(LAP_W)
    ) u_dut (
        .CLK(CLK), .RST_n(RST_n), .iStart(iStart), .iStop(iStop), .iClear(iClear),
        .iCntQ(cnt0), .oCntEn(en0), .oCntClr(clr0), .oLaps(laps0), .oBusy(busy0), .oDone(done0)
    );

    counter_seq_ctrl #(
        .DIV(1), .MOD(MOD), .CNT_W(CNT_W), .LAPS(LAPS), .LAP_W(LAP_W)
    ) u_div1 (
        .CLK(CLK), .RST_n(RST_n), .iStart(iStart), .iStop(iStop), .iClear(iClear),
        .iCntQ(cnt1), .oCntEn(en1), .oCntClr(clr1), .oLaps(laps1), .oBusy(busy1), .oDone(done1)
    );

    // Mod-8 counter datapaths controlled by each sequencer
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)    cnt0 <= '0;
        else if (clr0) cnt0 <= '0;
        else if (en0)  cnt0 <= cnt0 + 3'd1;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)    cnt1 <= '0;
        else if (clr1) cnt1 <= '0;
        else if (en1)  cnt1 <= cnt1 + 3'd1;
    end

    task automatic model_reset();
        m_mode = M_IDLE; m_ph = 0; m_laps = 0; m_cnt = 0; m_en = 1'b0; m_clr = 1'b0;
    endtask

    // Advance the reference model by one clock edge given the commands present before it.
    task automatic model_step(input bit s, input bit p, input bit c);
        bit wrap, fin, n_en, n_clr;
        int n_mode, n_ph, n_laps, n_cnt;
        wrap   = m_en && (m_cnt == MOD - 1);
        n_cnt  = m_clr ? 0 : (m_en ? (m_cnt + 1) % MOD : m_cnt);
        n_laps = wrap ? (m_laps + 1) % (1 << LAP_W) : m_laps;
        fin    = AUTOSTOP && wrap && (m_laps == LAPS - 1);
        n_mode = m_mode; n_ph = m_ph; n_en = 1'b0; n_clr = 1'b0;
        if (c) begin
            n_mode = M_IDLE; n_ph = 0; n_laps = 0; n_clr = 1'b1;
        end else if (fin) begin
            n_mode = M_DONE;
        end else if (m_mode == M_RUN) begin
            if (p) n_mode = M_PAUSE;
            else begin
                n_en = (m_ph == DIV - 1);
                n_ph = (m_ph + 1) % DIV;
            end
        end else if (s && !p) begin
            if (m_mode == M_DONE) begin n_laps = 0; n_clr = 1'b1; end
            if (m_mode != M_PAUSE) n_ph = 0;
            n_mode = M_RUN;
        end
        m_mode = n_mode; m_ph = n_ph; m_laps = n_laps; m_cnt = n_cnt; m_en = n_en; m_clr = n_clr;
    endtask

    // Present commands for one cycle (from a negedge) and return at the following negedge.
    task automatic tick_cmd(input bit s, input bit p, input bit c);
        iStart = s; iStop = p; iClear = c;
        model_step(s, p, c);
        @(posedge CLK);
        @(negedge CLK);
        iStart = 1'b0; iStop = 1'b0; iClear = 1'b0;
    endtask

    task automatic clean_up();
        tick_cmd(1'b0, 1'b0, 1'b1);
        tick_cmd(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        RST_n = 1'b0; iStart = 1'b0; iStop = 1'b0; iClear = 1'b0;
        model_reset();
        repeat (3) @(negedge CLK);
        n_chk++; if (en0 !== 1'b0)   $display("FAIL reset_en got=%b exp=0", en0);     else n_pass++;
        n_chk++; if (clr0 !== 1'b0)  $display("FAIL reset_clr got=%b exp=0", clr0);   else n_pass++;
        n_chk++; if (laps0 !== 4'd0) $display("FAIL reset_laps got=%0d exp=0", laps0); else n_pass++;
        n_chk++; if (busy0 !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy0); else n_pass++;
        n_chk++; if (done0 !== 1'b0) $display("FAIL reset_done got=%b exp=0", done0); else n_pass++;
        RST_n = 1'b1;
        tick_cmd(1'b0, 1'b0, 1'b0);
        n_chk++; if (busy0 !== 1'b0) $display("FAIL idle_busy got=%b exp=0", busy0);  else n_pass++;
        n_chk++; if (en0 !== 1'b0)   $display("FAIL idle_en got=%b exp=0", en0);      else n_pass++;
    endtask

    task automatic test_run_latency();
        logic e;
        tick_cmd(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 14; k++) begin
            e = (k == 5 || k == 9 || k == 13);
            n_chk++; if (en0 !== e)     $display("FAIL run_en cyc=%0d got=%b exp=%b", k, en0, e); else n_pass++;
            n_chk++; if (busy0 !== 1'b1) $display("FAIL run_busy cyc=%0d got=%b exp=1", k, busy0); else n_pass++;
            tick_cmd(1'b0, 1'b0, 1'b0);
        end
        tick_cmd(1'b0, 1'b0, 1'b1);
        n_chk++; if (clr0 !== 1'b1) $display("FAIL clr_pulse got=%b exp=1", clr0); else n_pass++;
        n_chk++; if (busy0 !== 1'b0) $display("FAIL clr_busy got=%b exp=0", busy0); else n_pass++;
        tick_cmd(1'b0, 1'b0, 1'b0);
        n_chk++; if (clr0 !== 1'b0) $display("FAIL clr_one_cycle got=%b exp=0", clr0); else n_pass++;
    endtask

    task automatic test_pause_resume();
        logic e;
        tick_cmd(1'b1, 1'b0, 1'b0);
        tick_cmd(1'b0, 1'b0, 1'b0);
        tick_cmd(1'b0, 1'b0, 1'b0);
        tick_cmd(1'b0, 1'b1, 1'b0);
        for (int j = 0; j < 6; j++) begin
            n_chk++; if (en0 !== 1'b0)   $display("FAIL pause_en j=%0d got=%b exp=0", j, en0);     else n_pass++;
            n_chk++; if (busy0 !== 1'b0) $display("FAIL pause_busy j=%0d got=%b exp=0", j, busy0); else n_pass++;
            tick_cmd(j == 2, j == 2 || j == 4, 1'b0);
        end
        tick_cmd(1'b1, 1'b0, 1'b0);
        for (int j = 1; j <= 3; j++) begin
            e = (j == 3);
            n_chk++; if (en0 !== e)      $display("FAIL resume_en j=%0d got=%b exp=%b", j, en0, e); else n_pass++;
            n_chk++; if (busy0 !== 1'b1) $display("FAIL resume_busy j=%0d got=%b exp=1", j, busy0); else n_pass++;
            tick_cmd(1'b0, 1'b0, 1'b0);
        end
        clean_up();
    endtask

    task automatic test_stop_on_tick();
        tick_cmd(1'b1, 1'b0, 1'b0);
        repeat (3) tick_cmd(1'b0, 1'b0, 1'b0);
        tick_cmd(1'b0, 1'b1, 1'b0);
        n_chk++; if (en0 !== 1'b0)   $display("FAIL stoptick_en got=%b exp=0", en0);     else n_pass++;
        n_chk++; if (busy0 !== 1'b0) $display("FAIL stoptick_busy got=%b exp=0", busy0); else n_pass++;
        tick_cmd(1'b0, 1'b0, 1'b0);
        n_chk++; if (en0 !== 1'b0)   $display("FAIL stoptick_en2 got=%b exp=0", en0);    else n_pass++;
        tick_cmd(1'b1, 1'b0, 1'b0);
        n_chk++; if (en0 !== 1'b0)   $display("FAIL stoptick_res1 got=%b exp=0", en0);   else n_pass++;
        n_chk++; if (busy0 !== 1'b1) $display("FAIL stoptick_busy2 got=%b exp=1", busy0); else n_pass++;
        tick_cmd(1'b0, 1'b0, 1'b0);
        n_chk++; if (en0 !== 1'b1)   $display("FAIL stoptick_res2 got=%b exp=1", en0);   else n_pass++;
        clean_up();
    endtask

    task automatic test_clear_with_start();
        tick_cmd(1'b1, 1'b0, 1'b0);
        repeat (39) tick_cmd(1'b0, 1'b0, 1'b0);
        n_chk++; if (laps0 !== 4'd1) $display("FAIL pre_clear_laps got=%0d exp=1", laps0); else n_pass++;
        n_chk++; if (cnt0 !== 3'd1)  $display("FAIL pre_clear_cnt got=%0d exp=1", cnt0);   else n_pass++;
        tick_cmd(1'b1, 1'b0, 1'b1);
        n_chk++; if (clr0 !== 1'b1)  $display("FAIL clrstart_clr got=%b exp=1", clr0);    else n_pass++;
        n_chk++; if (en0 !== 1'b0)   $display("FAIL clrstart_en got=%b exp=0", en0);      else n_pass++;
        n_chk++; if (laps0 !== 4'd0) $display("FAIL clrstart_laps got=%0d exp=0", laps0); else n_pass++;
        n_chk++; if (busy0 !== 1'b0) $display("FAIL clrstart_busy got=%b exp=0", busy0);  else n_pass++;
        tick_cmd(1'b0, 1'b0, 1'b0);
        n_chk++; if (clr0 !== 1'b0)  $display("FAIL clrstart_clr2 got=%b exp=0", clr0);   else n_pass++;
        n_chk++; if (cnt0 !== 3'd0)  $display("FAIL clrstart_cnt got=%0d exp=0", cnt0);   else n_pass++;
        n_chk++; if (busy0 !== 1'b0) $display("FAIL clrstart_idle got=%b exp=0", busy0);  else n_pass++;
    endtask

    task automatic test_laps();
        int   pulses;
        int   extra;
        int   exp_extra;
        logic e;
        pulses = 0;
        extra  = 0;
        tick_cmd(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 65; k++) begin
            pulses += int'(en0);
            tick_cmd(1'b0, 1'b0, 1'b0);
        end
        n_chk++; if (pulses != 16)    $display("FAIL laps_pulses got=%0d exp=16", pulses); else n_pass++;
        n_chk++; if (laps0 !== 4'd2)  $display("FAIL laps_count got=%0d exp=2", laps0);    else n_pass++;
        n_chk++; if (done0 !== AUTOSTOP)  $display("FAIL laps_done got=%b exp=%b", done0, AUTOSTOP);  else n_pass++;
        n_chk++; if (busy0 !== !AUTOSTOP) $display("FAIL laps_busy got=%b exp=%b", busy0, !AUTOSTOP); else n_pass++;
        for (int k = 66; k <= 75; k++) begin
            extra += int'(en0);
            tick_cmd(1'b0, 1'b0, 1'b0);
        end
        exp_extra = AUTOSTOP ? 0 : 2;
        n_chk++; if (extra != exp_extra) $display("FAIL laps_after got=%0d exp=%0d", extra, exp_extra); else n_pass++;
        tick_cmd(1'b1, 1'b0, 1'b0);
        n_chk++; if (clr0 !== AUTOSTOP) $display("FAIL restart_clr got=%b exp=%b", clr0, AUTOSTOP); else n_pass++;
        n_chk++; if (laps0 !== (AUTOSTOP ? 4'd0 : 4'd2)) $display("FAIL restart_laps got=%0d", laps0); else n_pass++;
        n_chk++; if (busy0 !== 1'b1) $display("FAIL restart_busy got=%b exp=1", busy0); else n_pass++;
        n_chk++; if (done0 !== 1'b0) $display("FAIL restart_done got=%b exp=0", done0); else n_pass++;
        for (int j = 1; j <= 5; j++) begin
            e = AUTOSTOP ? (j == 5) : (j == 1 || j == 5);
            n_chk++; if (en0 !== e) $display("FAIL restart_en j=%0d got=%b exp=%b", j, en0, e); else n_pass++;
            tick_cmd(1'b0, 1'b0, 1'b0);
        end
        clean_up();
    endtask

    task automatic test_random();
        bit s, p, c;
        for (int i = 0; i < 1000; i++) begin
            s = ($urandom_range(0, 7) == 0);
            p = ($urandom_range(0, 15) == 0);
            c = ($urandom_range(0, 59) == 0);
            tick_cmd(s, p, c);
            n_chk++; if (en0 !== m_en)   $display("FAIL rnd_en i=%0d got=%b exp=%b", i, en0, m_en);    else n_pass++;
            n_chk++; if (clr0 !== m_clr) $display("FAIL rnd_clr i=%0d got=%b exp=%b", i, clr0, m_clr); else n_pass++;
            n_chk++; if (laps0 !== 4'(m_laps)) $display("FAIL rnd_laps i=%0d got=%0d exp=%0d", i, laps0, m_laps); else n_pass++;
            n_chk++; if (busy0 !== (m_mode == M_RUN))  $display("FAIL rnd_busy i=%0d got=%b", i, busy0); else n_pass++;
            n_chk++; if (done0 !== (m_mode == M_DONE)) $display("FAIL rnd_done i=%0d got=%b", i, done0); else n_pass++;
            n_chk++; if (cnt0 !== 3'(m_cnt)) $display("FAIL rnd_cnt i=%0d got=%0d exp=%0d", i, cnt0, m_cnt); else n_pass++;
        end
        clean_up();
    endtask

    task automatic test_async_reset_div1();
        logic e;
        tick_cmd(1'b1, 1'b0, 1'b0);
        repeat (6) tick_cmd(1'b0, 1'b0, 1'b0);
        n_chk++; if (busy0 !== 1'b1) $display("FAIL prereset_busy got=%b exp=1", busy0); else n_pass++;
        #3;
        RST_n = 1'b0;
        #1;
        n_chk++; if (busy0 !== 1'b0) $display("FAIL areset_busy got=%b exp=0", busy0);   else n_pass++;
        n_chk++; if (busy1 !== 1'b0) $display("FAIL areset_busy1 got=%b exp=0", busy1);  else n_pass++;
        n_chk++; if (en1 !== 1'b0)   $display("FAIL areset_en1 got=%b exp=0", en1);      else n_pass++;
        n_chk++; if (en0 !== 1'b0)   $display("FAIL areset_en got=%b exp=0", en0);       else n_pass++;
        n_chk++; if (laps0 !== 4'd0) $display("FAIL areset_laps got=%0d exp=0", laps0);  else n_pass++;
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        RST_n = 1'b1;
        tick_cmd(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            e = (k >= 2) && (!AUTOSTOP || k <= 17);
            n_chk++; if (en1 !== e) $display("FAIL div1_en cyc=%0d got=%b exp=%b", k, en1, e); else n_pass++;
            if (k == 18) begin
                n_chk++; if (laps1 !== 4'd2) $display("FAIL div1_laps got=%0d exp=2", laps1); else n_pass++;
            end
            if (k == 20) begin
                n_chk++; if (done1 !== AUTOSTOP)  $display("FAIL div1_done got=%b exp=%b", done1, AUTOSTOP);  else n_pass++;
                n_chk++; if (busy1 !== !AUTOSTOP) $display("FAIL div1_busy got=%b exp=%b", busy1, !AUTOSTOP); else n_pass++;
            end
            tick_cmd(1'b0, 1'b0, 1'b0);
        end
        clean_up();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout after %0d checks", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_run_latency();
        test_pause_resume();
        test_stop_on_tick();
        test_clear_with_start();
        test_laps();
        test_random();
        test_async_reset_div1();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
